// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C master arbiter slice.
//            arb_state_t - arbiter FSM state encoding
//            byte_t      - one I2C data byte
//            MASTER_LEN_W - width of the master's read-length port
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   localparam int MASTER_LEN_W = 32;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_ERR_ACK   = 3'd4,
      ST_ERR_WAIT  = 3'd5
   } arb_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_rr_pick
// Purpose  : Combinational requester picker.
//            Default build: round-robin, search starts at ptr_i+1 and wraps,
//            ptr_i itself has the lowest priority.
//            With I2C_ARB_FIXED_PRIO_EN defined: lowest index wins and the
//            ptr_i port does not exist.
// Ports    : req_i     [N_REQ] request vector
//            ptr_i     [PTR_W] index of the last winner (round-robin only)
//            win_oh_o  [N_REQ] one-hot winner (0 when no request)
//            win_idx_o [PTR_W] winner index
//            any_o             at least one request pending
// Revision : 1.0 - initial release
// ============================================================================
module i2c_rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
`ifndef I2C_ARB_FIXED_PRIO_EN
   input  logic [PTR_W-1:0] ptr_i,
`endif
   output logic [N_REQ-1:0] win_oh_o,
   output logic [PTR_W-1:0] win_idx_o,
   output logic             any_o
);

`ifdef I2C_ARB_FIXED_PRIO_EN
   // Walk from the highest index down so the lowest set index is written last.
   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      any_o     = |req_i;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            win_oh_o    = '0;
            win_oh_o[i] = 1'b1;
            win_idx_o   = PTR_W'(i);
         end
      end
   end
`else
   // Walk the search offsets from farthest (ptr itself) to nearest (ptr+1);
   // the nearest requesting offset is written last and therefore wins.
   logic [PTR_W-1:0] idx;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      any_o     = |req_i;
      idx       = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = PTR_W'((int'(ptr_i) + i) % N_REQ);
         if (req_i[idx]) begin
            win_oh_o      = '0;
            win_oh_o[idx] = 1'b1;
            win_idx_o     = idx;
         end
      end
   end
`endif

endmodule : i2c_rr_pick
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Purpose  : Shares one i2c_master between N_REQ requesters. Picks a winner,
//            launches its transaction with a one-cycle command strobe,
//            streams its write bytes to the master, routes read bytes back,
//            reports done / NACK per requester and acknowledges master errors.
// Config   : I2C_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins),
//            round-robin pointer removed. Undefined: round-robin.
// Ports    : clock_i, reset_n_i (async, active low)
//            req_i/ctrl_wr_i/len_rd_i     per-requester transaction request
//            wr_valid_i/wr_data_i/wr_ready_o  per-requester write stream
//            rd_valid_o/rd_data_o         read bytes (data broadcast)
//            done_o/err_o                 per-requester completion pulses
//            grant_o                      one-hot current owner
//            m_*                          connection to i2c_master
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*8-1:0]      ctrl_wr_i,
   input  logic [N_REQ*8-1:0]      len_rd_i,
   input  logic [N_REQ-1:0]        wr_valid_i,
   input  logic [N_REQ*8-1:0]      wr_data_i,
   output logic [N_REQ-1:0]        wr_ready_o,
   output logic [N_REQ-1:0]        rd_valid_o,
   output logic [7:0]              rd_data_o,
   output logic [N_REQ-1:0]        done_o,
   output logic [N_REQ-1:0]        err_o,
   output logic [N_REQ-1:0]        grant_o,
   output logic                    m_cmd_strobe_o,
   output logic [7:0]              m_ctrl_wr_o,
   output logic [MASTER_LEN_W-1:0] m_len_rd_o,
   output logic                    m_data_available_o,
   output logic [7:0]              m_data_o,
   input  logic                    m_data_read_i,
   input  logic                    m_data_valid_i,
   input  logic [7:0]              m_data_i,
   input  logic                    m_busy_i,
   input  logic                    m_error_i,
   output logic                    m_ack_error_o
);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0] gidx_q,  gidx_d;
`ifndef I2C_ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0] ptr_q,   ptr_d;
`endif

   logic [N_REQ-1:0] win_oh;
   logic [PTR_W-1:0] win_idx;
   logic             win_any;
   logic             xfer_active;

   byte_t ctrl_arr [N_REQ];
   byte_t len_arr  [N_REQ];
   byte_t wdat_arr [N_REQ];

   for (genvar n = 0; n < N_REQ; n++) begin : g_unpack
      assign ctrl_arr[n] = ctrl_wr_i[8*n +: 8];
      assign len_arr[n]  = len_rd_i[8*n +: 8];
      assign wdat_arr[n] = wr_data_i[8*n +: 8];
   end

   i2c_rr_pick #(
      .N_REQ     (N_REQ),
      .PTR_W     (PTR_W)
   ) u_pick (
      .req_i     (req_i),
`ifndef I2C_ARB_FIXED_PRIO_EN
      .ptr_i     (ptr_q),
`endif
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .any_o     (win_any)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
`ifndef I2C_ARB_FIXED_PRIO_EN
         // Last winner = N_REQ-1 so requester 0 is searched first.
         ptr_q   <= PTR_W'(N_REQ - 1);
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
`ifndef I2C_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next state and control pulses
   // ------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      gidx_d         = gidx_q;
`ifndef I2C_ARB_FIXED_PRIO_EN
      ptr_d          = ptr_q;
`endif
      m_cmd_strobe_o = 1'b0;
      m_ack_error_o  = 1'b0;
      done_o         = '0;
      err_o          = '0;

      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               grant_d = win_oh;
               gidx_d  = win_idx;
`ifndef I2C_ARB_FIXED_PRIO_EN
               ptr_d   = win_idx;
`endif
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            m_cmd_strobe_o = 1'b1;
            state_d        = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (m_busy_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!m_busy_i) begin
               if (m_error_i) begin
                  err_o   = grant_q;
                  state_d = ST_ERR_ACK;
               end else begin
                  done_o  = grant_q;
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ERR_ACK: begin
            m_ack_error_o = 1'b1;
            state_d       = ST_ERR_WAIT;
         end
         ST_ERR_WAIT: begin
            // Grant is kept until the master has really dropped its error.
            if (!m_error_i) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Data paths (combinational, owner only)
   // ------------------------------------------------------------------------
   assign xfer_active = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_BUSY) ||
                        (state_q == ST_RUN);

   assign grant_o            = grant_q;
   assign m_ctrl_wr_o        = (state_q == ST_LAUNCH) ? ctrl_arr[gidx_q] : 8'h00;
   assign m_len_rd_o         = (state_q == ST_LAUNCH) ?
                               {{(MASTER_LEN_W-8){1'b0}}, len_arr[gidx_q]} : '0;
   assign m_data_available_o = xfer_active & wr_valid_i[gidx_q];
   assign m_data_o           = xfer_active ? wdat_arr[gidx_q] : 8'h00;
   // grant_q is one-hot, so masking it routes the strobe to the owner only.
   assign wr_ready_o         = (xfer_active && m_data_read_i) ? grant_q : '0;
   assign rd_valid_o         = ((state_q == ST_RUN) && m_data_valid_i) ? grant_q : '0;
   assign rd_data_o          = m_data_i;

endmodule : i2c_master_arbiter
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Purpose  : Self-checking bench for i2c_master_arbiter. A driver process
//            models the requesters and the i2c_master; directed tests push
//            expected DUT events into a queue; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

   localparam int N = 4;
   localparam int K_S = 0, K_W = 1, K_R = 2, K_D = 3, K_E = 4, K_A = 5;
   localparam int M_IDLE = 0, M_WR = 1, M_RD = 2, M_ERR = 3;

   typedef struct {
      int           kind;
      logic [N-1:0] vec;
      logic [31:0]  data;
      logic [31:0]  aux;
   } ev_t;

   ev_t  exp_q [$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic           clock_i   = 1'b0;
   logic           reset_n_i = 1'b0;
   logic [N-1:0]   req_i     = '0;
   logic [N*8-1:0] ctrl_wr_i = '0;
   logic [N*8-1:0] len_rd_i  = '0;
   logic [N-1:0]   wr_valid_i = '0;
   logic [N*8-1:0] wr_data_i = '0;
   logic [N-1:0]   wr_ready_o, rd_valid_o, done_o, err_o, grant_o;
   logic [7:0]     rd_data_o, m_ctrl_wr_o, m_data_o;
   logic [31:0]    m_len_rd_o;
   logic           m_cmd_strobe_o, m_data_available_o, m_ack_error_o;
   logic           m_data_read_i  = 1'b0;
   logic           m_data_valid_i = 1'b0;
   logic [7:0]     m_data_i       = 8'h00;
   logic           m_busy_i       = 1'b0;
   logic           m_error_i      = 1'b0;

   // Requester / master model state
   logic [7:0] wq [N][$];
   int         remaining [N];
   logic [7:0] rd_src [$];
   bit         nack_q [$];

   i2c_master_arbiter #(.N_REQ(N)) dut (
      .clock_i            (clock_i),
      .reset_n_i          (reset_n_i),
      .req_i              (req_i),
      .ctrl_wr_i          (ctrl_wr_i),
      .len_rd_i           (len_rd_i),
      .wr_valid_i         (wr_valid_i),
      .wr_data_i          (wr_data_i),
      .wr_ready_o         (wr_ready_o),
      .rd_valid_o         (rd_valid_o),
      .rd_data_o          (rd_data_o),
      .done_o             (done_o),
      .err_o              (err_o),
      .grant_o            (grant_o),
      .m_cmd_strobe_o     (m_cmd_strobe_o),
      .m_ctrl_wr_o        (m_ctrl_wr_o),
      .m_len_rd_o         (m_len_rd_o),
      .m_data_available_o (m_data_available_o),
      .m_data_o           (m_data_o),
      .m_data_read_i      (m_data_read_i),
      .m_data_valid_i     (m_data_valid_i),
      .m_data_i           (m_data_i),
      .m_busy_i           (m_busy_i),
      .m_error_i          (m_error_i),
      .m_ack_error_o      (m_ack_error_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic string kname(int k);
      case (k)
         K_S: return "strobe";
         K_W: return "wr_pop";
         K_R: return "rd_byte";
         K_D: return "done";
         K_E: return "err";
         default: return "ack_error";
      endcase
   endfunction

   function automatic void push_ev(int k, int n, logic [31:0] d, logic [31:0] a);
      ev_t e;
      e.kind = k;
      e.vec  = (n < 0) ? '0 : N'(1 << n);
      e.data = d;
      e.aux  = a;
      exp_q.push_back(e);
   endfunction

   task automatic check_ev(int k, logic [N-1:0] v, logic [31:0] d, logic [31:0] a);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: got vec=%b data=%h aux=%h, required no event",
                  kname(k), v, d, a);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.vec != v || e.data != d || e.aux != a) begin
            miscompares++;
            $display("FAIL %s: got %s vec=%b data=%h aux=%h, required %s vec=%b data=%h aux=%h",
                     kname(e.kind), kname(k), v, d, a, kname(e.kind), e.vec, e.data, e.aux);
         end
      end
   endtask

   task automatic check_val(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: every DUT output event is matched against the queue head
   // ------------------------------------------------------------------------
   initial begin : monitor
      forever begin
         @(negedge clock_i);
         if (reset_n_i) begin
            if (m_cmd_strobe_o)    check_ev(K_S, grant_o, {24'h0, m_ctrl_wr_o}, m_len_rd_o);
            if (wr_ready_o != '0)  check_ev(K_W, wr_ready_o, {24'h0, m_data_o},
                                            {31'h0, m_data_available_o});
            if (rd_valid_o != '0)  check_ev(K_R, rd_valid_o, {24'h0, rd_data_o}, 32'h0);
            if (done_o != '0)      check_ev(K_D, done_o, 32'h0, 32'h0);
            if (err_o != '0)       check_ev(K_E, err_o, 32'h0, 32'h0);
            if (m_ack_error_o)     check_ev(K_A, '0, 32'h0, 32'h0);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Driver: requesters and a behavioural i2c_master
   // ------------------------------------------------------------------------
   initial begin : driver
      int           ms      = M_IDLE;
      int           rd_left = 0;
      bit           cur_nack = 1'b0;
      logic         s_strobe, s_avail, s_ack;
      logic [7:0]   s_len;
      logic [N-1:0] s_pop, s_fin;
      forever begin
         @(negedge clock_i);
         s_strobe = m_cmd_strobe_o;
         s_len    = m_len_rd_o[7:0];
         s_avail  = m_data_available_o;
         s_ack    = m_ack_error_o;
         s_pop    = wr_ready_o;
         s_fin    = done_o | err_o;
         @(posedge clock_i);
         #1;
         if (!reset_n_i) begin
            ms = M_IDLE;
            m_busy_i = 1'b0; m_error_i = 1'b0; m_data_read_i = 1'b0;
            m_data_valid_i = 1'b0; m_data_i = 8'h00;
         end else begin
            for (int n = 0; n < N; n++) begin
               if (s_pop[n] && wq[n].size() != 0) void'(wq[n].pop_front());
               if (s_fin[n] && remaining[n] > 0) remaining[n]--;
            end
            case (ms)
               M_IDLE: if (s_strobe) begin
                  rd_left  = int'(s_len);
                  cur_nack = (nack_q.size() != 0) ? nack_q.pop_front() : 1'b0;
                  m_busy_i = 1'b1;
                  ms       = M_WR;
               end
               M_WR: begin
                  if (m_data_read_i)  m_data_read_i = 1'b0;
                  else if (s_avail)   m_data_read_i = 1'b1;
                  else                ms = M_RD;
               end
               M_RD: begin
                  if (m_data_valid_i) begin
                     m_data_valid_i = 1'b0;
                     m_data_i       = 8'h00;
                  end else if (rd_left > 0) begin
                     m_data_valid_i = 1'b1;
                     m_data_i       = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hEE;
                     rd_left--;
                  end else begin
                     m_busy_i  = 1'b0;
                     m_error_i = cur_nack;
                     ms        = cur_nack ? M_ERR : M_IDLE;
                  end
               end
               default: if (s_ack) begin
                  m_error_i = 1'b0;
                  ms        = M_IDLE;
               end
            endcase
         end
         for (int n = 0; n < N; n++) begin
            req_i[n]           = (remaining[n] > 0);
            wr_valid_i[n]      = (wq[n].size() != 0);
            wr_data_i[n*8 +: 8] = (wq[n].size() != 0) ? wq[n][0] : 8'h00;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Directed tests
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock_i);
      #3;
   endtask

   task automatic set_slices(int n, logic [7:0] ctrl, logic [7:0] len);
      ctrl_wr_i[n*8 +: 8] = ctrl;
      len_rd_i[n*8 +: 8]  = len;
   endtask

   function automatic bit pending();
      for (int n = 0; n < N; n++) if (remaining[n] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(string name, int budget);
      int cyc = 0;
      while ((exp_q.size() != 0 || grant_o != '0 || pending()) && cyc < budget) begin
         @(negedge clock_i);
         cyc++;
      end
      vectors++;
      if (cyc >= budget) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d events still outstanding after %0d cycles, required 0",
                  name, exp_q.size(), cyc);
      end
   endtask

   initial begin : main
      int c;
      int order [8];
      for (int n = 0; n < N; n++) remaining[n] = 0;

      // Reset state
      repeat (3) @(posedge clock_i);
      #3;
      check_val("reset_grant",  {28'h0, grant_o}, 32'h0);
      check_val("reset_pulses", {16'h0, done_o, err_o, wr_ready_o, rd_valid_o}, 32'h0);
      check_val("reset_master", {22'h0, m_cmd_strobe_o, m_ack_error_o, m_ctrl_wr_o}, 32'h0);
      check_val("reset_len",    m_len_rd_o, 32'h0);
      check_val("reset_wr",     {23'h0, m_data_available_o, m_data_o}, 32'h0);
      reset_n_i = 1'b1;
      tick();

      // T1: req 0, two write bytes, no read
      set_slices(0, 8'hA0, 8'h00);
      wq[0].push_back(8'h10);
      wq[0].push_back(8'h55);
      push_ev(K_S, 0, 32'hA0, 32'h0);
      push_ev(K_W, 0, 32'h10, 32'h1);
      push_ev(K_W, 0, 32'h55, 32'h1);
      push_ev(K_D, 0, 32'h0, 32'h0);
      remaining[0] = 1;
      c = 0;
      @(negedge clock_i);
      while (!req_i[0] && c < 10) begin
         @(negedge clock_i);
         c++;
      end
      @(negedge clock_i);
      check_val("launch_latency", {31'h0, m_cmd_strobe_o}, 32'h1);
      wait_idle("t1", 100);

      // T2: requesters 1 and 3 together -> 1 then 3
      set_slices(1, 8'h42, 8'h00);
      set_slices(3, 8'h46, 8'h00);
      push_ev(K_S, 1, 32'h42, 32'h0);
      push_ev(K_D, 1, 32'h0, 32'h0);
      push_ev(K_S, 3, 32'h46, 32'h0);
      push_ev(K_D, 3, 32'h0, 32'h0);
      remaining[1] = 1;
      remaining[3] = 1;
      wait_idle("t2", 100);

      // T3: all four requesting for two transactions each
`ifdef I2C_ARB_FIXED_PRIO_EN
      order = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
      order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      for (int n = 0; n < N; n++) set_slices(n, 8'h50 + 8'(n), 8'h00);
      for (int k = 0; k < 8; k++) begin
         push_ev(K_S, order[k], 32'h50 + 32'(order[k]), 32'h0);
         push_ev(K_D, order[k], 32'h0, 32'h0);
      end
      for (int n = 0; n < N; n++) remaining[n] = 2;
      wait_idle("t3", 300);

      // T4: requester 2 reads three bytes
      set_slices(2, 8'hA1, 8'd3);
      rd_src.push_back(8'h01);
      rd_src.push_back(8'h02);
      rd_src.push_back(8'h03);
      push_ev(K_S, 2, 32'hA1, 32'd3);
      push_ev(K_R, 2, 32'h01, 32'h0);
      push_ev(K_R, 2, 32'h02, 32'h0);
      push_ev(K_R, 2, 32'h03, 32'h0);
      push_ev(K_D, 2, 32'h0, 32'h0);
      remaining[2] = 1;
      wait_idle("t4", 100);

      // T5: NACK on requester 1, requester 3 pending behind it
      set_slices(1, 8'hB2, 8'h00);
      set_slices(3, 8'hB6, 8'h00);
      wq[1].push_back(8'h77);
      nack_q.push_back(1'b1);
      push_ev(K_S, 1, 32'hB2, 32'h0);
      push_ev(K_W, 1, 32'h77, 32'h1);
      push_ev(K_E, 1, 32'h0, 32'h0);
      push_ev(K_A, -1, 32'h0, 32'h0);
      push_ev(K_S, 3, 32'hB6, 32'h0);
      push_ev(K_D, 3, 32'h0, 32'h0);
      remaining[1] = 1;
      tick();
      tick();
      remaining[3] = 1;
      wait_idle("t5", 150);

      // T6: asynchronous reset in RUN
      set_slices(0, 8'hA3, 8'd8);
      for (int b = 0; b < 8; b++) rd_src.push_back(8'h80 + 8'(b));
      push_ev(K_S, 0, 32'hA3, 32'd8);
      for (int b = 0; b < 8; b++) push_ev(K_R, 0, 32'h80 + 32'(b), 32'h0);
      push_ev(K_D, 0, 32'h0, 32'h0);
      remaining[0] = 1;
      c = 0;
      @(negedge clock_i);
      while (rd_valid_o == '0 && c < 50) begin
         @(negedge clock_i);
         c++;
      end
      check_val("run_reached", {31'h0, rd_valid_o[0]}, 32'h1);
      tick();
      reset_n_i = 1'b0;
      exp_q.delete();
      rd_src.delete();
      nack_q.delete();
      for (int n = 0; n < N; n++) begin
         remaining[n] = 0;
         wq[n].delete();
      end
      #1;
      check_val("async_rst_grant",  {28'h0, grant_o}, 32'h0);
      check_val("async_rst_pulses", {16'h0, done_o, err_o, wr_ready_o, rd_valid_o}, 32'h0);
      check_val("async_rst_master", {30'h0, m_cmd_strobe_o, m_ack_error_o}, 32'h0);
      tick();
      tick();
      reset_n_i = 1'b1;
      tick();
      set_slices(2, 8'hC4, 8'h00);
      push_ev(K_S, 2, 32'hC4, 32'h0);
      push_ev(K_D, 2, 32'h0, 32'h0);
      remaining[2] = 1;
      c = 0;
      @(negedge clock_i);
      while (!req_i[2] && c < 10) begin
         @(negedge clock_i);
         c++;
      end
      c = 0;
      while (grant_o != 4'b0100 && c < 2) begin
         @(negedge clock_i);
         c++;
      end
      check_val("post_reset_grant", {28'h0, grant_o}, 32'h4);
      wait_idle("t6", 100);

      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_events: got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule : tb_i2c_master_arbiter
`default_nettype wire
